// File: rtl/census_transform_3x3.sv
// rtl/census_transform_3x3.sv - streaming 3x3 census transform with two line buffers
module census_transform_3x3 #(
   parameter int IMG_WIDTH    = 640,
   parameter int PIXEL_WIDTH  = 8,
   parameter int CENSUS_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [PIXEL_WIDTH-1:0]  pixel_in,
   input  logic                    valid_in,
   input  logic                    sof_in,
   output logic [CENSUS_WIDTH-1:0] census_out,
   output logic                    valid_out,
   output logic                    sof_out
);

   localparam int            CW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);

   // raster position of the current pixel
   logic [CW-1:0]          col_q, col_d, col_cur;
   logic [1:0]             row_q, row_d, row_cur;

   // line buffers: lb0 holds the previous line, lb1 the one before it
   logic [PIXEL_WIDTH-1:0] lb0_q [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0] lb1_q [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0] top_px, mid_px;

   // window: row 0 = top, column 0 = oldest (c-2), column 2 = newest (c)
   logic [PIXEL_WIDTH-1:0] win_q [3][3];

   // pipeline stage 1 (window loaded), stage 2 (code computed)
   logic                   v1_q, s1_q, b1_q;
   logic                   border_d;
   logic                   v2_q, s2_q;
   logic [7:0]             census_d;
   logic [7:0]             code_q;

   // Position of the pixel being accepted; sof forces it to (0,0) and the
   // counters' next state follows from that forced position.
   always_comb begin
      col_cur  = col_q;
      row_cur  = row_q;
      col_d    = col_q;
      row_d    = row_q;
      if (valid_in && sof_in) begin
         col_cur = '0;
         row_cur = '0;
      end
      border_d = (row_cur < 2'd2) || (col_cur < COL_TWO);
      if (valid_in) begin
         if (col_cur == COL_LAST) begin
            col_d = '0;
            row_d = (row_cur == 2'd2) ? 2'd2 : row_cur + 2'd1;
         end else begin
            col_d = col_cur + CW'(1);
            row_d = row_cur;
         end
      end
   end

   // Column/row counters; row saturates at 2 since only "row >= 2" matters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign top_px = lb1_q[col_cur];
   assign mid_px = lb0_q[col_cur];

   // Line buffers shift down one line per accepted pixel (read before write).
   always_ff @(posedge clk) begin
      if (valid_in) begin
         lb1_q[col_cur] <= lb0_q[col_cur];
         lb0_q[col_cur] <= pixel_in;
      end
   end

   // Window shifts left and takes the new column {top, mid, pixel_in}.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else if (valid_in) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
         end
         win_q[0][2] <= top_px;
         win_q[1][2] <= mid_px;
         win_q[2][2] <= pixel_in;
      end
   end

   // Stage 1 control: valid, sof and border flag travel with the window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         s1_q <= 1'b0;
         b1_q <= 1'b1;
      end else begin
         v1_q <= valid_in;
         s1_q <= valid_in && sof_in;
         if (valid_in) begin
            b1_q <= border_d;
         end
      end
   end

   // Census bits: neighbour strictly less than the centre, TL in bit 7.
   always_comb begin
      census_d    = '0;
      census_d[7] = win_q[0][0] < win_q[1][1];
      census_d[6] = win_q[0][1] < win_q[1][1];
      census_d[5] = win_q[0][2] < win_q[1][1];
      census_d[4] = win_q[1][0] < win_q[1][1];
      census_d[3] = win_q[1][2] < win_q[1][1];
      census_d[2] = win_q[2][0] < win_q[1][1];
      census_d[1] = win_q[2][1] < win_q[1][1];
      census_d[0] = win_q[2][2] < win_q[1][1];
   end

   // Stage 2: register the code, zeroed for border positions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q   <= 1'b0;
         s2_q   <= 1'b0;
         code_q <= '0;
      end else begin
         v2_q <= v1_q;
         s2_q <= s1_q;
         if (v1_q) begin
            code_q <= b1_q ? 8'h00 : census_d;
         end
      end
   end

   // Output stage: code holds its last value while valid_out is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         census_out <= '0;
         valid_out  <= 1'b0;
         sof_out    <= 1'b0;
      end else begin
         valid_out <= v2_q;
         sof_out   <= s2_q;
         if (v2_q) begin
            census_out <= CENSUS_WIDTH'(code_q);
         end
      end
   end

endmodule

// File: tb/tb_census_transform_3x3.sv
// tb/tb_census_transform_3x3.sv - directed bench for census_transform_3x3
module tb_census_transform_3x3;

   logic       clk;
   logic       rst_n;
   logic [7:0] pixel_in;
   logic       valid_in;
   logic       sof_in;
   logic [7:0] census_out;
   logic       valid_out;
   logic       sof_out;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic [7:0] exp_code [$];
   logic       exp_sof  [$];
   int         exp_edge [$];

   census_transform_3x3 #(
      .IMG_WIDTH    (4),
      .PIXEL_WIDTH  (8),
      .CENSUS_WIDTH (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pixel_in   (pixel_in),
      .valid_in   (valid_in),
      .sof_in     (sof_in),
      .census_out (census_out),
      .valid_out  (valid_out),
      .sof_out    (sof_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Output monitor: every valid_out must match the oldest pending pixel.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valid_out === 1'b1) begin
         if (exp_code.size() == 0) begin
            check("extra_valid_out", 1, 0);
         end else begin
            check("latency", cyc, exp_edge.pop_front() + 2);
            check("census", census_out, exp_code.pop_front());
            check("sof_out", sof_out, exp_sof.pop_front());
         end
      end
   end

   task automatic idle();
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      sof_in   = 1'($urandom_range(0, 1));
      pixel_in = 8'($urandom_range(0, 255));
   endtask

   task automatic drive(input logic [7:0] p, input logic s, input logic [7:0] code);
      @(posedge clk);
      #1;
      pixel_in = p;
      valid_in = 1'b1;
      sof_in   = s;
      exp_code.push_back(code);
      exp_sof.push_back(s);
      exp_edge.push_back(cyc + 1);
   endtask

   task automatic drain();
      idle();
      valid_in = 1'b0;
      sof_in   = 1'b0;
      for (int i = 0; i < 20 && exp_code.size() != 0; i++) @(posedge clk);
      check("drain", exp_code.size(), 0);
      repeat (3) @(posedge clk);
   endtask

   // kind 0: uniform 100, kind 1: gradient 10r+c, kind 2: 50 with (1,1)=60
   task automatic run_frame(input int kind, input int max_gap);
      logic [7:0] p, code;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            case (kind)
               0: begin
                  p    = 8'd100;
                  code = 8'h00;
               end
               1: begin
                  p    = 8'(10 * r + c);
                  code = (r >= 2 && c >= 2) ? 8'hF0 : 8'h00;
               end
               default: begin
                  p    = (r == 1 && c == 1) ? 8'd60 : 8'd50;
                  code = (r == 2 && c == 2) ? 8'hFF : 8'h00;
               end
            endcase
            if (max_gap > 0) begin
               repeat ($urandom_range(0, max_gap)) idle();
            end
            drive(p, (r == 0 && c == 0), code);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      valid_in = 1'b0;
      sof_in   = 1'b0;
      pixel_in = 8'h00;

      // reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         valid_in = 1'($urandom_range(0, 1));
         sof_in   = 1'($urandom_range(0, 1));
         pixel_in = 8'($urandom_range(0, 255));
         @(negedge clk);
         check("rst_census", census_out, 0);
         check("rst_valid", valid_out, 0);
         check("rst_sof", sof_out, 0);
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      sof_in   = 1'b0;
      rst_n    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_valid", valid_out, 0);
      end

      run_frame(0, 0);
      drain();
      run_frame(1, 0);
      drain();
      run_frame(2, 0);
      drain();
      run_frame(1, 3);
      drain();

      // re-sync: old frame reaches (1,1), sof lands where (1,2) would be
      for (int i = 0; i < 6; i++) begin
         drive(8'(10 * (i / 4) + (i % 4)), (i == 0), 8'h00);
      end
      run_frame(1, 0);
      drain();

      // asynchronous reset mid-row
      for (int i = 0; i < 5; i++) begin
         drive(8'(i), (i == 0), 8'h00);
      end
      #1;
      check("pre_rst_valid", valid_out, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_valid", valid_out, 0);
      check("async_census", census_out, 0);
      check("async_sof", sof_out, 0);
      exp_code.delete();
      exp_sof.delete();
      exp_edge.delete();
      valid_in = 1'b0;
      sof_in   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
